// File: rtl/accum_writeback_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : accum_writeback_ctrl                                            |
// | Purpose  : Drains a block of accumulator rows into the unified buffer.     |
// |            Each 32-bit signed lane is rounded half-up, arithmetically      |
// |            right-shifted and saturated to an 8-bit activation. A two-entry |
// |            result buffer absorbs write-grant back-pressure.                |
// | Ports    : clk_i, rst_i (async, active-low)                                |
// |            start_i/rows_i/acc_base_i/ub_base_i/shift_i - job launch        |
// |            busy_o, done_o                              - job status        |
// |            acc_rd_en_o/acc_addr_rd_o/acc_data_i        - accumulator read  |
// |            ub_wr_o/ub_grant_i/ub_addr_wr_o/ub_data_o   - buffer write      |
// | Options  : TPU_WB_RELU_EN adds relu_i; negative lanes are zeroed before    |
// |            rounding when the latched relu flag is set.                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module accum_writeback_ctrl #(
  parameter int LANES  = 16,
  parameter int RES_W  = 32,
  parameter int ACT_W  = 8,
  parameter int ACC_AW = 7,
  parameter int UB_AW  = 12
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [ACC_AW:0]          rows_i,
  input  logic [ACC_AW-1:0]        acc_base_i,
  input  logic [UB_AW-1:0]         ub_base_i,
  input  logic [4:0]               shift_i,
`ifdef TPU_WB_RELU_EN
  input  logic                     relu_i,
`endif
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     acc_rd_en_o,
  output logic [ACC_AW-1:0]        acc_addr_rd_o,
  input  logic [LANES*RES_W-1:0]   acc_data_i,
  output logic                     ub_wr_o,
  input  logic                     ub_grant_i,
  output logic [UB_AW-1:0]         ub_addr_wr_o,
  output logic [LANES*ACT_W-1:0]   ub_data_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic signed [RES_W:0] SAT_MAX = (RES_W+1)'((1 << (ACT_W-1)) - 1);
  localparam logic signed [RES_W:0] SAT_MIN = ~SAT_MAX;
  localparam logic [ACC_AW:0]       ONE_ROW = (ACC_AW+1)'(1);

  state_t                   state_q;
  logic [ACC_AW:0]          rows_q;
  logic [ACC_AW-1:0]        acc_base_q;
  logic [UB_AW-1:0]         ub_base_q;
  logic [4:0]               shift_q;
  logic [ACC_AW:0]          rd_cnt_q;
  logic [ACC_AW:0]          wr_cnt_q;
  logic                     d_vld_q;
  logic [1:0]               cnt_q;
  logic [LANES*ACT_W-1:0]   buf0_q;
  logic [LANES*ACT_W-1:0]   buf1_q;
  logic                     relu_en;

  logic                     accept;
  logic [1:0]               occ;
  logic                     rd_issue;
  logic [LANES*ACT_W-1:0]   req_d;

`ifdef TPU_WB_RELU_EN
  logic relu_q;
  assign relu_en = relu_q;
`else
  assign relu_en = 1'b0;
`endif

  // Round half-up, arithmetic shift and saturate one lane. The extra bit
  // keeps the rounding add from overflowing for values near +2^(RES_W-1).
  function automatic logic [ACT_W-1:0] requant(input logic [RES_W-1:0] x,
                                               input logic [4:0]       sh,
                                               input logic             relu);
    logic signed [RES_W:0] xe;
    logic signed [RES_W:0] rnd;
    logic signed [RES_W:0] y;
    xe  = (relu && x[RES_W-1]) ? '0 : $signed({x[RES_W-1], x});
    rnd = '0;
    if (sh != 5'd0) rnd = (RES_W+1)'(1) << (sh - 5'd1);
    y = (xe + rnd) >>> sh;
    if (y > SAT_MAX)      return SAT_MAX[ACT_W-1:0];
    else if (y < SAT_MIN) return SAT_MIN[ACT_W-1:0];
    else                  return y[ACT_W-1:0];
  endfunction

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign req_d[k*ACT_W +: ACT_W] = requant(acc_data_i[k*RES_W +: RES_W], shift_q, relu_en);
  end

  assign ub_wr_o      = (cnt_q != 2'd0);
  assign accept       = ub_wr_o & ub_grant_i;
  // Entries still held after this cycle's accept, plus the row whose data
  // lands this cycle. A new read is only safe while that total is below two.
  assign occ          = cnt_q - {1'b0, accept} + {1'b0, d_vld_q};
  assign rd_issue     = (state_q == S_RUN) && (occ < 2'd2);

  assign acc_rd_en_o   = rd_issue;
  assign acc_addr_rd_o = acc_base_q + rd_cnt_q[ACC_AW-1:0];
  assign ub_addr_wr_o  = ub_base_q + UB_AW'(wr_cnt_q);
  assign ub_data_o     = buf0_q;
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      rows_q     <= '0;
      acc_base_q <= '0;
      ub_base_q  <= '0;
      shift_q    <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      d_vld_q    <= 1'b0;
      cnt_q      <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
`ifdef TPU_WB_RELU_EN
      relu_q     <= 1'b0;
`endif
    end else begin
      d_vld_q <= rd_issue;
      if (accept) wr_cnt_q <= wr_cnt_q + ONE_ROW;

      // Buffer entry 0 is always the head presented on the write port.
      case ({d_vld_q, accept})
        2'b10: begin
          if (cnt_q == 2'd0) buf0_q <= req_d;
          else               buf1_q <= req_d;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          buf0_q <= buf1_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            buf0_q <= req_d;
          end else begin
            buf0_q <= buf1_q;
            buf1_q <= req_d;
          end
        end
        default: ;
      endcase

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            rows_q     <= rows_i;
            acc_base_q <= acc_base_i;
            ub_base_q  <= ub_base_i;
            shift_q    <= shift_i;
`ifdef TPU_WB_RELU_EN
            relu_q     <= relu_i;
`endif
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            state_q    <= (rows_i == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (rd_issue) begin
            rd_cnt_q <= rd_cnt_q + ONE_ROW;
            if (rd_cnt_q + ONE_ROW == rows_q) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (accept && (wr_cnt_q + ONE_ROW == rows_q)) state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_accum_writeback_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_accum_writeback_ctrl                                         |
// | Purpose  : Self-checking bench for accum_writeback_ctrl. An accumulator    |
// |            memory model answers reads; expected writes come from an        |
// |            integer requantization model and are matched in order.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_accum_writeback_ctrl;

  localparam int LANES  = 16;
  localparam int RES_W  = 32;
  localparam int ACT_W  = 8;
  localparam int ACC_AW = 7;
  localparam int UB_AW  = 12;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   start_i;
  logic [ACC_AW:0]        rows_i;
  logic [ACC_AW-1:0]      acc_base_i;
  logic [UB_AW-1:0]       ub_base_i;
  logic [4:0]             shift_i;
`ifdef TPU_WB_RELU_EN
  logic                   relu_i;
`endif
  logic                   busy_o, done_o, acc_rd_en_o, ub_wr_o, ub_grant_i;
  logic [ACC_AW-1:0]      acc_addr_rd_o;
  logic [LANES*RES_W-1:0] acc_data_i;
  logic [UB_AW-1:0]       ub_addr_wr_o;
  logic [LANES*ACT_W-1:0] ub_data_o;

  accum_writeback_ctrl #(
    .LANES(LANES), .RES_W(RES_W), .ACT_W(ACT_W), .ACC_AW(ACC_AW), .UB_AW(UB_AW)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .rows_i       (rows_i),
    .acc_base_i   (acc_base_i),
    .ub_base_i    (ub_base_i),
    .shift_i      (shift_i),
`ifdef TPU_WB_RELU_EN
    .relu_i       (relu_i),
`endif
    .busy_o       (busy_o),
    .done_o       (done_o),
    .acc_rd_en_o  (acc_rd_en_o),
    .acc_addr_rd_o(acc_addr_rd_o),
    .acc_data_i   (acc_data_i),
    .ub_wr_o      (ub_wr_o),
    .ub_grant_i   (ub_grant_i),
    .ub_addr_wr_o (ub_addr_wr_o),
    .ub_data_o    (ub_data_o)
  );

  always #5 clk_i = ~clk_i;

  // Accumulator memory: data appears the cycle after the read strobe and is
  // garbage otherwise, so late or early sampling is visible.
  logic [LANES*RES_W-1:0] acc_mem [128];
  always @(posedge clk_i)
    acc_data_i <= acc_rd_en_o ? acc_mem[acc_addr_rd_o] : {LANES{32'hDEAD_BEEF}};

  typedef struct {
    logic [UB_AW-1:0]       addr;
    logic [LANES*ACT_W-1:0] data;
  } wr_item_t;

  wr_item_t exp_q [$];
  int total, bad;
  int cyc, rd_seen, wr_seen, first_wr, last_wr, rd_c1, rd_c2, max_occ;
  bit prev_stall;
  logic [UB_AW-1:0]       prev_addr;
  logic [LANES*ACT_W-1:0] prev_data;
  bit gpat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  function automatic void chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endfunction

  function automatic int ref_requant(int x, int sh, bit relu);
    longint v, d;
    v = x;
    if (relu && v < 0) v = 0;
    if (sh > 0) begin
      d = longint'(1) << sh;
      v = v + d / 2;
      if (v >= 0) v = v / d;
      else        v = -((-v + d - 1) / d);
    end
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return int'(v);
  endfunction

  function automatic logic [LANES*ACT_W-1:0] exp_row(input logic [LANES*RES_W-1:0] row,
                                                      input int sh, input bit relu);
    logic [LANES*ACT_W-1:0] r;
    logic [RES_W-1:0]       lane;
    int                     y;
    for (int k = 0; k < LANES; k++) begin
      lane = row[k*RES_W +: RES_W];
      y    = ref_requant($signed(lane), sh, relu);
      r[k*ACT_W +: ACT_W] = ACT_W'(y);
    end
    return r;
  endfunction

  task automatic set_row(input int idx, input int a, input int b, input int c, input int d);
    int v [4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int k = 0; k < LANES; k++) acc_mem[idx][k*RES_W +: RES_W] = 32'(v[k % 4]);
  endtask

  task automatic fill_random();
    int t;
    for (int r = 0; r < 128; r++)
      for (int k = 0; k < LANES; k++) begin
        case ($urandom_range(0, 3))
          0: t = int'($urandom);
          1: t = int'($urandom_range(0, 2000)) - 1000;
          2: t = int'($urandom_range(0, 60)) - 30;
          default: t = int'($urandom_range(0, 1 << 20)) - (1 << 19);
        endcase
        acc_mem[r][k*RES_W +: RES_W] = 32'(t);
      end
  endtask

  task automatic advance(input int gmode);
    @(posedge clk_i); #1;
    cyc++;
    start_i = 1'b0;
    case (gmode)
      0:       ub_grant_i = 1'b1;
      1:       ub_grant_i = gpat[(cyc - 1) % 6];
      default: ub_grant_i = ($urandom_range(0, 9) < 6);
    endcase
    #1;
  endtask

  task automatic monitor(input int n, input int abase);
    wr_item_t          it;
    int                occ;
    logic [ACC_AW-1:0] ea;
    occ = rd_c2 - wr_seen;
    if (occ > max_occ) max_occ = occ;
    if (prev_stall) begin
      chk("stall_wr", ub_wr_o, 1'b1);
      chk("stall_addr", ub_addr_wr_o, prev_addr);
      chk("stall_data", ub_data_o, prev_data);
    end
    if (acc_rd_en_o) begin
      ea = ACC_AW'((abase + rd_seen) % 128);
      chk("rd_extra", rd_seen < n, 1'b1);
      chk("rd_addr", acc_addr_rd_o, ea);
      rd_seen++;
    end
    if (ub_wr_o && ub_grant_i) begin
      chk("wr_extra", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        it = exp_q.pop_front();
        chk("wr_addr", ub_addr_wr_o, it.addr);
        chk("wr_data", ub_data_o, it.data);
      end
      if (wr_seen == 0) first_wr = cyc;
      last_wr = cyc;
      wr_seen++;
    end
    prev_stall = ub_wr_o && !ub_grant_i;
    prev_addr  = ub_addr_wr_o;
    prev_data  = ub_data_o;
    rd_c2 = rd_c1;
    rd_c1 = rd_seen;
  endtask

  // Launch a job from the current (idle) cycle, which becomes cycle 0.
  task automatic run_job(input int n, input int abase, input int ubase, input int sh,
                         input bit relu, input int gmode, input bit timed, input bit poke);
    wr_item_t it;
    bit       fin;
    int       done_cyc;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      it.addr = UB_AW'((ubase + i) % 4096);
      it.data = exp_row(acc_mem[(abase + i) % 128], sh, relu);
      exp_q.push_back(it);
    end
    cyc = 0; rd_seen = 0; wr_seen = 0; first_wr = -1; last_wr = -1;
    rd_c1 = 0; rd_c2 = 0; max_occ = 0; prev_stall = 1'b0;
    fin = 1'b0; done_cyc = -1;
    rows_i     = (ACC_AW+1)'(n);
    acc_base_i = ACC_AW'(abase);
    ub_base_i  = UB_AW'(ubase);
    shift_i    = 5'(sh);
`ifdef TPU_WB_RELU_EN
    relu_i     = relu;
`endif
    start_i    = 1'b1;
    while (!fin && cyc < 2000) begin
      advance(gmode);
      if (poke && cyc >= 1 && cyc <= 3) begin
        start_i = 1'b1; rows_i = 8'd5; acc_base_i = '0; ub_base_i = '0; shift_i = 5'd0;
      end
      chk("busy", busy_o, 1'b1);
      monitor(n, abase);
      if (done_o) begin
        fin = 1'b1;
        done_cyc = cyc;
      end
    end
    chk("job_finished", fin, 1'b1);
    chk("rows_left", exp_q.size(), 0);
    chk("reads_total", rd_seen, n);
    chk("occupancy_le2", max_occ <= 2, 1'b1);
    if (timed) begin
      chk("done_cycle", done_cyc, (n == 0) ? 1 : n + 3);
      if (n > 0) begin
        chk("first_wr_cycle", first_wr, 3);
        chk("last_wr_cycle", last_wr, n + 2);
      end
    end
    advance(1);
    chk("done_pulse", done_o, 1'b0);
    chk("idle_busy", busy_o, 1'b0);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    rst_i = 1'b0; start_i = 1'b0; rows_i = '0; acc_base_i = '0; ub_base_i = '0;
    shift_i = '0; ub_grant_i = 1'b1;
`ifdef TPU_WB_RELU_EN
    relu_i = 1'b0;
`endif
    fill_random();
    repeat (3) @(posedge clk_i);
    #2;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_rd_en", acc_rd_en_o, 1'b0);
    chk("rst_ub_wr", ub_wr_o, 1'b0);
    chk("rst_rd_addr", acc_addr_rd_o, '0);
    chk("rst_wr_addr", ub_addr_wr_o, '0);
    chk("rst_ub_data", ub_data_o, '0);
    @(negedge clk_i);
    rst_i = 1'b1;
    advance(0);
    chk("post_rst_busy", busy_o, 1'b0);

    // Directed saturation job with exact timing.
    for (int r = 0; r < 4; r++) set_row(r, 5, -3, 200, -200);
    run_job(4, 0, 'h100, 0, 1'b0, 0, 1'b1, 1'b0);

    // Round-half-up with shift 4.
    for (int r = 10; r < 12; r++) set_row(r, 24, 23, -24, -25);
    run_job(2, 10, 'h200, 4, 1'b0, 0, 1'b1, 1'b0);

    // Address wrap on both sides.
    run_job(3, 126, 'hFFF, 3, 1'b0, 0, 1'b1, 1'b0);

    // Grant toggling 1,0,0,1,0,1 over eight rows.
    run_job(8, 20, 'h300, 2, 1'b0, 1, 1'b0, 1'b0);

    // Empty job.
    run_job(0, 5, 0, 0, 1'b0, 0, 1'b1, 1'b0);

    // start_i pulsed during RUN must not disturb the job.
    run_job(8, 40, 'h400, 1, 1'b0, 0, 1'b1, 1'b1);

    // Randomized jobs with random grant.
    for (int j = 0; j < 8; j++) begin
      fill_random();
      run_job((j == 0) ? 128 : int'($urandom_range(1, 24)), int'($urandom_range(0, 127)),
              int'($urandom_range(0, 4095)), int'($urandom_range(0, 31)), 1'b0, 2, 1'b0, 1'b0);
    end

    // Reset asserted mid-job.
    rows_i = 8'd10; acc_base_i = 7'd60; ub_base_i = 12'h500; shift_i = 5'd0; start_i = 1'b1;
    repeat (4) advance(0);
    #1 rst_i = 1'b0;
    #1;
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_done", done_o, 1'b0);
    chk("mid_rst_rd_en", acc_rd_en_o, 1'b0);
    chk("mid_rst_ub_wr", ub_wr_o, 1'b0);
    chk("mid_rst_rd_addr", acc_addr_rd_o, '0);
    chk("mid_rst_wr_addr", ub_addr_wr_o, '0);
    chk("mid_rst_ub_data", ub_data_o, '0);
    @(posedge clk_i);
    #3 rst_i = 1'b1;
    advance(0);
    chk("after_rst_busy", busy_o, 1'b0);
    chk("after_rst_ub_wr", ub_wr_o, 1'b0);
    run_job(5, 60, 'h500, 0, 1'b0, 0, 1'b1, 1'b0);

`ifdef TPU_WB_RELU_EN
    set_row(50, -7, 7, -7, 7);
    run_job(1, 50, 'h10, 1, 1'b1, 0, 1'b1, 1'b0);
    run_job(1, 50, 'h20, 1, 1'b0, 0, 1'b1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/accum_writeback_ctrl.md
# accum_writeback_ctrl

Sequencer that drains a block of accumulator rows into the unified buffer once a matrix-multiply pass has finished. It issues accumulator reads and requantizes each 32-bit partial-sum lane to an 8-bit activation using a round-half-up arithmetic shift and signed saturation. It writes the resulting row to the unified buffer through a shared write port gated by a grant, and absorbs grant back-pressure with a two-entry result buffer.

## Interface
Parameters:
- LANES, 16, activation/result lanes per row (systolic array width)
- RES_W, 32, accumulator lane width (signed)
- ACT_W, 8, unified buffer lane width (signed)
- ACC_AW, 7, accumulator address width
- UB_AW, 12, unified buffer address width

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset; asynchronous, active-low
- start_i  in  1  launch a writeback job; sampled only in IDLE
- rows_i  in  ACC_AW+1  rows to transfer, 0..2^ACC_AW
- acc_base_i  in  ACC_AW  first accumulator row
- ub_base_i  in  UB_AW  first unified buffer row
- shift_i  in  5  requantization right-shift amount, 0..31
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle pulse at job end
- acc_rd_en_o  out  1  accumulator read strobe
- acc_addr_rd_o  out  ACC_AW  accumulator read address
- acc_data_i  in  LANES x RES_W  read data, valid the cycle after acc_rd_en_o
- ub_wr_o  out  1  unified buffer write request
- ub_grant_i  in  1  write port granted; a write is accepted when ub_wr_o && ub_grant_i
- ub_addr_wr_o  out  UB_AW  unified buffer write address
- ub_data_o  out  LANES x ACT_W  requantized row

## Operation
- Job parameters (rows, bases, shift) are latched on start_i in IDLE. start_i is ignored at all other times.
- State machine:
  - IDLE: on start_i, go to RUN (rows>0) or DONE (rows=0).
  - RUN: issue reads; after the last read issues, go to DRAIN.
  - DRAIN: wait until every row is written, then go to DONE.
  - DONE: assert done_o for one cycle, then go to IDLE.
- Read issue rule: issue a read only if (entries held + reads in flight) < 2, counting an entry as freed when it is accepted in the same cycle. The buffer therefore never overflows.
- Row i read address = (acc_base + i) mod 2^ACC_AW. Write address = (ub_base + i) mod 2^UB_AW. Both wrap silently.
- Per-lane requantization, where x is the signed RES_W value:
  - shift=0: y=x.
  - shift>0: y = (x + 2^(shift-1)) >>> shift, with the addition done in RES_W+1 bits.
  - Saturate y to [-2^(ACT_W-1), 2^(ACT_W-1)-1].
- Rows are written in order. ub_wr_o, ub_addr_wr_o and ub_data_o stay stable while ub_wr_o=1 and ub_grant_i=0.
- busy_o is 1 in RUN, DRAIN and DONE.

## Timing
- Reset values: busy_o, done_o, acc_rd_en_o and ub_wr_o are 0. acc_addr_rd_o, ub_addr_wr_o and ub_data_o are 0. Buffer is empty and state is IDLE.
- Reset asserted mid-job: all outputs return to reset values immediately; in-flight data is discarded.
- start_i sampled in cycle 0. First acc_rd_en_o is in cycle 1. Data arrives in cycle 2 and is requantized into the buffer at the end of cycle 2. First ub_wr_o is in cycle 3.
- With ub_grant_i held at 1, throughput is one row per cycle. For N rows, the last write is in cycle N+2 and done_o is in cycle N+3.
- rows=0: done_o in cycle 1, with no reads or writes.
- done_o is asserted the cycle after the final write is accepted. A new start_i is accepted the cycle after done_o.

## Configuration
- TPU_WB_RELU_EN defined:
  - An extra port, relu_i (in, 1), is latched with the job.
  - When relu_i=1, negative lanes are forced to 0 before rounding and the shift.
- TPU_WB_RELU_EN undefined: relu_i does not exist and requantization is purely signed.

## Test plan
- rows=4, acc_base=0, ub_base=0x100, shift=0, grant tied 1, lane values {5,-3,200,-200} → writes to 0x100..0x103 in cycles 3..6 carrying {5,-3,127,-128}; done_o in cycle 7.
- shift=4, lane values {24,23,-24,-25} → {2,1,-1,-2} (round-half-up).
- rows=3, acc_base=126, ub_base=0xFFF → reads from 126,127,0; writes to 0xFFF,0x000,0x001.
- grant toggled 1,0,0,1,0,1,... over 8 rows → no row lost or duplicated, data held stable while stalled, at most 2 rows buffered, all 8 rows written in order.
- rows=0 → done_o in cycle 1; start_i asserted during RUN is ignored; reset asserted mid-job → outputs 0 at once and state returns to IDLE.
- With TPU_WB_RELU_EN, relu_i=1, shift=1, value -7 → 0, value 7 → 4.
